// File: rtl/mealy_input_stage.sv
// mealy_input_stage: conditions the raw up/down/clear pushbuttons of the
// Mealy up/down sequence decoder and owns its 4-bit state register.
// Each key is synchronised, debounced and turned into a one-cycle press
// pulse. The state register advances on the edge that ends the pulse.
// Optional feature: define HOLD_REPEAT_EN to auto-repeat held up/down keys.
module mealy_input_stage #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int MAX_STATE       = 8,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       KeyUp,
  input  logic       KeyDown,
  input  logic       KeyClr,
  output logic       Up,
  output logic       Down,
  output logic       ClrOut,
  output logic [3:0] state
);

  localparam int unsigned NK = 3;  // key index: 0 = up, 1 = down, 2 = clear
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] ST_MAX = 4'(MAX_STATE);
  localparam logic [3:0] ST_ERR = 4'hF;

  // Reject parameter values the datapath cannot support.
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || MAX_STATE < 1 || MAX_STATE > 14 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("mealy_input_stage: unsupported parameter value");
  end

  logic [NK-1:0]          w_raw;
  logic [SYNC_STAGES-1:0] r_sync [NK];
  logic [CW-1:0]          r_cnt  [NK];
  logic [NK-1:0]          r_deb;
  logic [NK-1:0]          r_deb_d;
  logic [NK-1:0]          w_fall;
  logic [1:0]             w_rep;
  logic                   w_ev_up;
  logic                   w_ev_dn;
  logic                   w_ev_clr;

  assign w_raw = {KeyClr, KeyDown, KeyUp};

  // Synchronise each key, then flip the debounced level only after
  // DEBOUNCE_CYCLES consecutive samples that differ from it.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned k = 0; k < NK; k++) begin
        r_sync[k] <= '1;
        r_cnt[k]  <= '0;
      end
      r_deb   <= '1;
      r_deb_d <= '1;
    end else begin
      r_deb_d <= r_deb;
      for (int unsigned k = 0; k < NK; k++) begin
        r_sync[k] <= {r_sync[k][SYNC_STAGES-2:0], w_raw[k]};
        if (r_sync[k][SYNC_STAGES-1] == r_deb[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == DB_LAST) begin
          r_deb[k] <= r_sync[k][SYNC_STAGES-1];
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  // Press = debounced level falling; releases are ignored.
  assign w_fall = r_deb_d & ~r_deb;

`ifdef HOLD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX) + 1;
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] r_hold [2];
  logic [1:0]    r_armed;

  // Repeat fires after the initial delay, then once per period while held.
  always_comb begin
    w_rep = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      w_rep[k] = ~r_deb[k] & (r_armed[k] ? (r_hold[k] == RP_LAST) : (r_hold[k] == RD_LAST));
    end
  end

  // Hold counters for up/down run while the debounced key is pressed.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned k = 0; k < 2; k++) begin
        r_hold[k] <= '0;
      end
      r_armed <= '0;
    end else begin
      for (int unsigned k = 0; k < 2; k++) begin
        if (r_deb[k]) begin
          r_hold[k]  <= '0;
          r_armed[k] <= 1'b0;
        end else if (w_rep[k]) begin
          r_hold[k]  <= '0;
          r_armed[k] <= 1'b1;
        end else begin
          r_hold[k] <= r_hold[k] + 1'b1;
        end
      end
    end
  end
`else
  assign w_rep = '0;
`endif

  assign w_ev_up  = w_fall[0] | w_rep[0];
  assign w_ev_dn  = w_fall[1] | w_rep[1];
  assign w_ev_clr = w_fall[2];

  // Register the pulses; clear overrides any concurrent up/down event.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Up     <= 1'b0;
      Down   <= 1'b0;
      ClrOut <= 1'b0;
    end else if (w_ev_clr) begin
      Up     <= 1'b0;
      Down   <= 1'b0;
      ClrOut <= 1'b1;
    end else begin
      Up     <= w_ev_up;
      Down   <= w_ev_dn;
      ClrOut <= 1'b0;
    end
  end

  // Sequence state advances on the edge ending the pulse cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= '0;
    end else if (ClrOut) begin
      state <= '0;
    end else if (Up || Down) begin
      if (state != ST_ERR && state > ST_MAX) begin
        state <= '0;
      end else if (Up && Down) begin
        state <= ST_ERR;
      end else if (state == ST_ERR) begin
        state <= '0;
      end else if (Up) begin
        state <= (state == ST_MAX) ? 4'd0 : state + 4'd1;
      end else begin
        state <= (state == 4'd0) ? ST_MAX : state - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mealy_input_stage.sv
// Scoreboard bench for mealy_input_stage (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_mealy_input_stage;

  localparam int SS   = 2;
  localparam int DC   = 4;
  localparam int MAXS = 8;
  localparam int LAT  = SS + DC + 1;  // drive at negedge N -> pulse seen at negedge N+LAT

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       KeyUp = 1'b1;
  logic       KeyDown = 1'b1;
  logic       KeyClr = 1'b1;
  logic       Up;
  logic       Down;
  logic       ClrOut;
  logic [3:0] state;

  mealy_input_stage #(
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DC),
    .MAX_STATE(MAXS),
    .REPEAT_DELAY(1000),
    .REPEAT_PERIOD(500)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .KeyUp(KeyUp),
    .KeyDown(KeyDown),
    .KeyClr(KeyClr),
    .Up(Up),
    .Down(Down),
    .ClrOut(ClrOut),
    .state(state)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit up;
    bit dn;
    bit clr;
    int prev;
    int next;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_state = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference rule for the sequence: mod-(MAXS+1) counter with error state 15.
  function automatic int model_next(input int s, input bit u, input bit d, input bit c);
    if (c) return 0;
    if (u && d) return 15;
    if (s == 15) return 0;
    if (u) return (s + 1) % (MAXS + 1);
    return (s + MAXS) % (MAXS + 1);
  endfunction

  task automatic push(input bit u, input bit d, input bit c, input int at);
    exp_t e;
    e.cyc  = at;
    e.up   = u && !c;
    e.dn   = d && !c;
    e.clr  = c;
    e.prev = m_state;
    e.next = model_next(m_state, u, d, c);
    m_state = e.next;
    q.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever a pulse appears, checks hold otherwise.
  int   exp_state = 0;
  bit   pend = 0;
  int   pend_val = 0;
  exp_t me;
  always @(negedge Clock) begin
    if (!Reset) begin
      pend = 0;
      exp_state = 0;
      chk("reset_up", Up, 0);
      chk("reset_down", Down, 0);
      chk("reset_clr", ClrOut, 0);
      chk("reset_state", state, 0);
    end else begin
      if (pend) begin
        chk("next_state", state, pend_val);
        exp_state = pend_val;
        pend = 0;
      end else if (!(Up || Down || ClrOut)) begin
        chk("hold_state", state, exp_state);
      end
      if (Up || Down || ClrOut) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pulse: got up=%0d down=%0d clr=%0d at cycle %0d, required no pulse",
                   Up, Down, ClrOut, cyc);
        end else begin
          me = q.pop_front();
          chk("pulse_cycle", cyc, me.cyc);
          chk("pulse_up", Up, me.up);
          chk("pulse_down", Down, me.dn);
          chk("pulse_clr", ClrOut, me.clr);
          chk("state_during_pulse", state, me.prev);
          pend = 1;
          pend_val = me.next;
        end
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        me = q.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL missing_pulse: got none by cycle %0d, required pulse at cycle %0d", cyc, me.cyc);
        exp_state = me.next;
      end
    end
  end

  task automatic press(input bit u, input bit d, input bit c, input int hold, input int gap);
    @(negedge Clock);
    push(u, d, c, cyc + LAT);
    if (u) KeyUp = 1'b0;
    if (d) KeyDown = 1'b0;
    if (c) KeyClr = 1'b0;
    repeat (hold) @(negedge Clock);
    KeyUp = 1'b1;
    KeyDown = 1'b1;
    KeyClr = 1'b1;
    repeat (gap) @(negedge Clock);
  endtask

  task automatic glitch(input bit u, input bit d, input bit c, input int len);
    @(negedge Clock);
    if (u) KeyUp = 1'b0;
    if (d) KeyDown = 1'b0;
    if (c) KeyClr = 1'b0;
    repeat (len) @(negedge Clock);
    KeyUp = 1'b1;
    KeyDown = 1'b1;
    KeyClr = 1'b1;
    repeat (12) @(negedge Clock);
  endtask

  initial begin
    int target;
    int r;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    repeat (100) @(negedge Clock);

    // First press, held long: exactly one pulse.
    press(1, 0, 0, 30, 12);
    // Sub-threshold glitches on down.
    for (int i = 0; i < 4; i++) glitch(0, 1, 0, DC - 1);
    // Complete the wrap through MAX_STATE back to 0, then down wraps to MAX.
    for (int i = 0; i < 8; i++) press(1, 0, 0, 10, 12);
    press(0, 1, 0, 10, 12);
    // Simultaneous up/down -> error state, then up recovers to 0.
    press(1, 1, 0, 10, 12);
    press(1, 0, 0, 10, 12);
    // Reach 5, then clear and up together.
    for (int i = 0; i < 5; i++) press(1, 0, 0, 10, 12);
    press(1, 0, 1, 10, 12);

    // Reset asserted mid-debounce with a nonzero state.
    press(1, 0, 0, 10, 12);
    @(negedge Clock);
    KeyDown = 1'b0;
    repeat (3) @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    chk("async_state", state, 0);
    chk("async_down", Down, 0);
    m_state = 0;
    KeyDown = 1'b1;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    repeat (12) @(negedge Clock);

    // Reset asserted mid-pulse, key held across reset: one fresh pulse after.
    press(0, 1, 0, 10, 12);
    @(negedge Clock);
    target = cyc + LAT;
    push(1, 0, 0, target);
    KeyUp = 1'b0;
    while (cyc < target) @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    chk("async_pulse_up", Up, 0);
    chk("async_pulse_state", state, 0);
    m_state = 0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    push(1, 0, 0, cyc + LAT);
    repeat (15) @(negedge Clock);
    KeyUp = 1'b1;
    repeat (12) @(negedge Clock);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: press(1, 0, 0, $urandom_range(8, 20), $urandom_range(10, 20));
        1: press(0, 1, 0, $urandom_range(8, 20), $urandom_range(10, 20));
        2: press(1, 1, 0, $urandom_range(8, 20), $urandom_range(10, 20));
        3: press(0, 0, 1, $urandom_range(8, 20), $urandom_range(10, 20));
        4: press(1, 0, 1, $urandom_range(8, 20), $urandom_range(10, 20));
        default: glitch($urandom_range(0, 1) == 1, 1, $urandom_range(0, 1) == 1,
                        $urandom_range(1, DC - 1));
      endcase
    end

    repeat (20) @(negedge Clock);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mealy_input_stage.md
Name: mealy_input_stage

Overview:
- Upstream stage of the Mealy up/down sequence decoder. Conditions three raw active-low pushbuttons (up, down, clear): synchronise, debounce, then emit press pulses.
- Owns the 4-bit state register (mod-9 sequence plus error state 15).
- Drives the decoder's Up, Down, Reset and state inputs directly.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per key (min 2).
- DEBOUNCE_CYCLES, 50000, consecutive stable samples before the debounced level flips (1 ms at 50 MHz; min 2).
- MAX_STATE, 8, highest legal sequence state; sequence wraps MAX_STATE <-> 0.
- REPEAT_DELAY, 25000000, hold time before auto-repeat starts (optional feature only).
- REPEAT_PERIOD, 10000000, auto-repeat interval (optional feature only).

Ports:
- Clock  input  1  system clock; all flops rise-edge.
- Reset  input  1  asynchronous, active-low reset.
- KeyUp  input  1  raw up button; 0 = pressed; asynchronous.
- KeyDown  input  1  raw down button; 0 = pressed; asynchronous.
- KeyClr  input  1  raw clear button; 0 = pressed; asynchronous.
- Up  output  1  registered one-cycle press pulse to the decoder.
- Down  output  1  registered one-cycle press pulse to the decoder.
- ClrOut  output  1  registered one-cycle clear pulse; drives the decoder's Reset input.
- state  output  4  registered current sequence state (0..MAX_STATE, or 15).

Behaviour:
- Reset (Reset=0, asynchronous):
  - Up=0, Down=0, ClrOut=0, state=0.
  - Synchroniser flops and debounced levels = 1 (released); debounce and repeat counters = 0.
- Per key, synchroniser: SYNC_STAGES flops, first stage samples the raw key.
- Per key, debounce:
  - Counter width is $clog2(DEBOUNCE_CYCLES)+1.
  - Counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the synced level and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES samples produces no change.
- Press event = debounced level falling 1->0. Release produces no event.
- Latency: first clock edge sampling the new raw level at edge 0 -> press pulse high after edge SYNC_STAGES+DEBOUNCE_CYCLES, for exactly one cycle.
- Pulse generation, same cycle, priority order:
  1. Clear event: ClrOut=1, Up=0, Down=0, regardless of up/down events.
  2. Otherwise Up=up event, Down=down event. Both events in the same cycle give Up=1 and Down=1 together.
- State update: registered on the edge that ends the pulse cycle, so the decoder sees old state plus the pulse (Mealy output) for one cycle.
  - ClrOut=1 -> 0.
  - Up=1 and Down=1 -> 15.
  - state=15 and exactly one of Up/Down -> 0.
  - Up only: MAX_STATE -> 0, else +1.
  - Down only: 0 -> MAX_STATE, else -1.
  - No pulse -> hold.
- Illegal state values (MAX_STATE+1..14) are unreachable; if present, any pulse forces 0.
- Holding a key generates exactly one pulse unless the optional feature is enabled. A second pulse requires release, debounce of the release, then a fresh press.
- Reset asserted mid-debounce or mid-pulse: everything returns to reset values immediately. After deassertion, keys still held down are debounced as new presses, one pulse each.

Optional Feature:
- Macro HOLD_REPEAT_EN.
- Defined: per up/down key, a hold counter runs while the debounced level = 0.
  - After REPEAT_DELAY cycles of hold, an extra press event is generated.
  - Further events every REPEAT_PERIOD cycles until release; counter clears on release.
  - Clear never repeats.
  - Repeat events obey the same priority and simultaneity rules.
- Undefined: no hold counters synthesised; one pulse per press.

Test Plan:
- Apply reset, then hold Reset=1 with all keys released for 100 cycles -> Up=Down=ClrOut=0, state=0 throughout.
- SYNC_STAGES=2, DEBOUNCE_CYCLES=4; KeyUp low at edge 0 and held -> Up=1 only in the cycle after edge 6; state 0->1 at edge 7; no further pulses while held.
- DEBOUNCE_CYCLES=4; KeyDown glitches low for 3 samples, repeated -> no Down pulse, state unchanged.
- Nine clean Up presses from state 0 -> state sequence 1..8 then 0. One Down press from 0 -> state 8.
- KeyUp and KeyDown pressed on the same edge -> Up=Down=1 for one cycle, state=15. Then one Up press -> state=0.
- At state 5, clear and up pressed on the same edge -> ClrOut=1, Up=0, state=0. Reset asserted mid-debounce -> outputs return to 0 asynchronously.
